// File: rtl/fft_peak_finder.sv
// fft_peak_finder: captures a 16-bin complex FFT frame, squares each bin's
// magnitude serially through a two-stage pipeline (square, compare) and
// reports the index of the strongest bin with a one-cycle analysis_done pulse.
// Optional build macro: PEAK_MAG_OUT_EN adds the peak_mag output port.
//
// Handshake: fft_valid is a one-cycle strobe with no ready signal. A frame is
// taken when the FSM is IDLE or on the last scan cycle (idx = NBIN-1); a
// strobe at any other time is dropped and flagged by a one-cycle overrun.
module fft_peak_finder #(
    parameter int NBIN = 16,
    parameter int DW   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fft_valid,
    input  logic [2*DW-1:0]   fft_d0,
    input  logic [2*DW-1:0]   fft_d1,
    input  logic [2*DW-1:0]   fft_d2,
    input  logic [2*DW-1:0]   fft_d3,
    input  logic [2*DW-1:0]   fft_d4,
    input  logic [2*DW-1:0]   fft_d5,
    input  logic [2*DW-1:0]   fft_d6,
    input  logic [2*DW-1:0]   fft_d7,
    input  logic [2*DW-1:0]   fft_d8,
    input  logic [2*DW-1:0]   fft_d9,
    input  logic [2*DW-1:0]   fft_d10,
    input  logic [2*DW-1:0]   fft_d11,
    input  logic [2*DW-1:0]   fft_d12,
    input  logic [2*DW-1:0]   fft_d13,
    input  logic [2*DW-1:0]   fft_d14,
    input  logic [2*DW-1:0]   fft_d15,
    output logic              analysis_done,
    output logic [3:0]        freq,
`ifdef PEAK_MAG_OUT_EN
    output logic [2*DW-1:0]   peak_mag,
`endif
    output logic              overrun,
    output logic              state_dbg
);

    localparam int IW = $clog2(NBIN);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBIN - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t            state, next_state;
    logic              accept, drop;
    logic [IW-1:0]     idx;
    logic [2*DW-1:0]   bin_buf [NBIN];

    // Stage 1 (square) registers
    logic              s1_valid, s1_first, s1_last;
    logic [IW-1:0]     s1_idx;
    logic [2*DW-1:0]   mag1;

    // Stage 2 (compare) registers
    logic              s2_last;
    logic [2*DW-1:0]   max_q;
    logic [IW-1:0]     maxidx;

    // Squaring datapath on the currently addressed bin
    logic signed [DW-1:0]   re, im;
    logic signed [2*DW-1:0] re_ext, im_ext, re_sq, im_sq;
    logic [2*DW-1:0]        mag_sum;

    assign state_dbg = state;

    assign re      = bin_buf[idx][2*DW-1:DW];
    assign im      = bin_buf[idx][DW-1:0];
    assign re_ext  = re;
    assign im_ext  = im;
    // Each square fits in 2*DW signed bits; the sum peaks at 2^(2*DW-1).
    assign re_sq   = re_ext * re_ext;
    assign im_sq   = im_ext * im_ext;
    assign mag_sum = $unsigned(re_sq) + $unsigned(im_sq);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // FSM next-state and frame accept/drop decode
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE: begin
                if (fft_valid) begin
                    accept     = 1'b1;
                    next_state = SCAN;
                end
            end
            SCAN: begin
                if (idx == LAST_IDX) begin
                    if (fft_valid) accept = 1'b1;
                    else           next_state = IDLE;
                end else if (fft_valid) begin
                    drop = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Scan index: restarts on every accepted frame, advances while scanning
    always_ff @(posedge clk) begin
        if (!rst)            idx <= '0;
        else if (accept)     idx <= '0;
        else if (state == SCAN) idx <= idx + 1'b1;
    end

    // Frame buffer load; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (accept) begin
            bin_buf[0]  <= fft_d0;
            bin_buf[1]  <= fft_d1;
            bin_buf[2]  <= fft_d2;
            bin_buf[3]  <= fft_d3;
            bin_buf[4]  <= fft_d4;
            bin_buf[5]  <= fft_d5;
            bin_buf[6]  <= fft_d6;
            bin_buf[7]  <= fft_d7;
            bin_buf[8]  <= fft_d8;
            bin_buf[9]  <= fft_d9;
            bin_buf[10] <= fft_d10;
            bin_buf[11] <= fft_d11;
            bin_buf[12] <= fft_d12;
            bin_buf[13] <= fft_d13;
            bin_buf[14] <= fft_d14;
            bin_buf[15] <= fft_d15;
        end
    end

    // Stage 1: register the squared magnitude with its index and frame tags
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_idx   <= '0;
            mag1     <= '0;
        end else begin
            s1_valid <= (state == SCAN);
            s1_first <= (idx == '0);
            s1_last  <= (idx == LAST_IDX);
            s1_idx   <= idx;
            mag1     <= mag_sum;
        end
    end

    // Stage 2: running maximum; first tag restarts it so frames may overlap
    always_ff @(posedge clk) begin
        if (!rst) begin
            s2_last <= 1'b0;
            max_q   <= '0;
            maxidx  <= '0;
        end else begin
            s2_last <= s1_valid && s1_last;
            if (s1_valid && (s1_first || (mag1 > max_q))) begin
                max_q  <= mag1;
                maxidx <= s1_idx;
            end
        end
    end

    // Result registers: publish the frame's peak one edge after its last compare
    always_ff @(posedge clk) begin
        if (!rst) begin
            analysis_done <= 1'b0;
            overrun       <= 1'b0;
            freq          <= '0;
`ifdef PEAK_MAG_OUT_EN
            peak_mag      <= '0;
`endif
        end else begin
            analysis_done <= s2_last;
            overrun       <= drop;
            if (s2_last) begin
                freq     <= 4'(maxidx);
`ifdef PEAK_MAG_OUT_EN
                peak_mag <= max_q;
`endif
            end
        end
    end

endmodule
